// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1-style deserialiser with a two-flop line synchroniser.
// It delivers right-justified bytes with a one-clock rx_done_tick strobe and a registered framing-error flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // A stop phase longer than 16 ticks (1.5 or 2 stop bits) needs a wider tick counter.
  localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int SHIFT = 8 - DBIT;
  localparam logic [SW-1:0] S_MID  = SW'(32'd7);
  localparam logic [SW-1:0] S_BIT  = SW'(32'd15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  logic          sync1_r, sync2_r;
  logic          rx_s;
  logic [1:0]    state_r, state_s;
  logic [SW-1:0] s_r, s_s;
  logic [2:0]    n_r, n_s;
  logic [7:0]    shift_r, shift_s;
  logic [7:0]    dout_r, dout_s;
  logic          frame_err_r, frame_err_s;
  logic          done_s;

  assign rx_s = sync2_r;

  // Two-flop synchroniser for the asynchronous serial line; it resets to the idle (high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  // Frame FSM next-state logic: it counts ticks to mid-bit and shifts the data in LSB first.
  always_comb begin
    state_s     = state_r;
    s_s         = s_r;
    n_s         = n_r;
    shift_s     = shift_r;
    dout_s      = dout_r;
    frame_err_s = frame_err_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_s = START;
          s_s     = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_r == S_MID) begin
            // The start bit must still be low at its midpoint; otherwise the edge was a glitch.
            if (!rx_s) begin
              state_s = DATA;
              s_s     = '0;
              n_s     = 3'd0;
            end else begin
              state_s = IDLE;
              s_s     = '0;
            end
          end else begin
            s_s = s_r + SW'(32'd1);
          end
        end else begin
          s_s = s_r;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_r == S_BIT) begin
            shift_s = {rx_s, shift_r[7:1]};
            s_s     = '0;
            if (n_r == N_LAST) begin
              state_s = STOP;
            end else begin
              n_s = n_r + 3'd1;
            end
          end else begin
            s_s = s_r + SW'(32'd1);
          end
        end else begin
          s_s = s_r;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_r == S_STOP) begin
            state_s     = IDLE;
            s_s         = '0;
            done_s      = 1'b1;
            frame_err_s = ~rx_s;
            dout_s      = shift_r >> SHIFT;
          end else begin
            s_s = s_r + SW'(32'd1);
          end
        end else begin
          s_s = s_r;
        end
      end
      default: begin
        state_s = IDLE;
        s_s     = '0;
        n_s     = 3'd0;
      end
    endcase
  end

  // State, counters and output registers; a reset mid-frame discards the partial byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      s_r         <= '0;
      n_r         <= 3'd0;
      shift_r     <= 8'h00;
      dout_r      <= 8'h00;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      s_r         <= s_s;
      n_r         <= n_s;
      shift_r     <= shift_s;
      dout_r      <= dout_s;
      frame_err_r <= frame_err_s;
    end
  end

  assign dout         = dout_r;
  assign frame_err    = frame_err_r;
  assign rx_done_tick = done_s;
  assign rx_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8-bit instance on a 1-in-3 clock tick and a 7-bit, 2-stop-bit
// instance fed by a bench-side transmitter model that ticks every clock.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic       s_tick = 1'b0;
  logic       s_tick_b;
  logic [1:0] tick_cnt = 2'd0;
  logic [7:0] dout_a, dout_b;
  logic       done_a, done_b, ferr_a, ferr_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;
  int strobes_a = 0;
  int strobes_b = 0;
  logic [8:0] sb_a[$];
  logic [8:0] sb_b[$];
  logic pend_a = 1'b0;
  logic pend_b = 1'b0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk(clk), .reset(rst_n), .rx(rx_a), .s_tick(s_tick),
    .dout(dout_a), .rx_done_tick(done_a), .frame_err(ferr_a), .rx_busy(busy_a));

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut_b (
    .clk(clk), .reset(rst_n), .rx(rx_b), .s_tick(s_tick_b),
    .dout(dout_b), .rx_done_tick(done_b), .frame_err(ferr_b), .rx_busy(busy_b));

  always #5 clk = ~clk;

  // One tick every third clock for instance A.
  always @(posedge clk) begin
    tick_cnt <= (tick_cnt == 2'd2) ? 2'd0 : tick_cnt + 2'd1;
    s_tick   <= (tick_cnt == 2'd2);
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor A: one clock after each strobe the registered outputs must hold the expected frame.
  always @(negedge clk) begin
    logic [8:0] e;
    if (pend_a) begin
      tests++;
      strobes_a++;
      if (sb_a.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_strobe: got dout %0h expected no frame", dout_a);
      end else begin
        e = sb_a.pop_front();
        if (dout_a !== e[7:0] || ferr_a !== e[8] || busy_a !== 1'b0 || done_a !== 1'b0) begin
          fails++;
          $display("FAIL a_frame: got dout %0h ferr %0b busy %0b done %0b expected dout %0h ferr %0b busy 0 done 0",
                   dout_a, ferr_a, busy_a, done_a, e[7:0], e[8]);
        end
      end
    end
    pend_a = done_a;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (pend_b) begin
      tests++;
      strobes_b++;
      if (sb_b.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_strobe: got dout %0h expected no frame", dout_b);
      end else begin
        e = sb_b.pop_front();
        if (dout_b !== e[7:0] || ferr_b !== e[8] || done_b !== 1'b0) begin
          fails++;
          $display("FAIL b_frame: got dout %0h ferr %0b done %0b expected dout %0h ferr %0b done 0",
                   dout_b, ferr_b, done_b, e[7:0], e[8]);
        end
      end
    end
    pend_b = done_b;
  end

  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic ticks_b(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop_ok);
    sb_a.push_back({~stop_ok, d});
    rx_a = 1'b0;
    ticks_a(16);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      ticks_a(16);
    end
    if (stop_ok) begin
      rx_a = 1'b1;
      ticks_a(16);
    end else begin
      // A low stop bit is released early so the trailing low is rejected as a glitch.
      rx_a = 1'b0;
      ticks_a(12);
      rx_a = 1'b1;
      ticks_a(4);
    end
  endtask

  task automatic send_b(input logic [7:0] d);
    sb_b.push_back({1'b0, 1'b0, d[6:0]});
    rx_b = 1'b0;
    ticks_b(16);
    for (int i = 0; i < 7; i++) begin
      rx_b = d[i];
      ticks_b(16);
    end
    rx_b = 1'b1;
    ticks_b(32);
  endtask

  initial begin
    logic [7:0] d;
    int cnt;
    s_tick_b = 1'b1;
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {1'b0, dout_a}, 9'h000);
    check("rst_flags", {6'd0, ferr_a, busy_a, done_a}, 9'h000);
    check("rst_b_dout", {1'b0, dout_b}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    ticks_a(20);

    send_a(8'hA5, 1'b1);
    ticks_a(4);
    check("t1_busy", {8'd0, busy_a}, 9'h000);

    cnt = strobes_a;
    rx_a = 1'b0;
    ticks_a(4);
    rx_a = 1'b1;
    ticks_a(24);
    check("t2_no_strobe", 9'(strobes_a - cnt), 9'h000);
    check("t2_busy", {8'd0, busy_a}, 9'h000);
    check("t2_hold", {ferr_a, dout_a}, 9'h0A5);

    send_a(8'h3C, 1'b0);
    ticks_a(16);
    send_a(8'h01, 1'b1);
    ticks_a(16);

    send_a(8'h00, 1'b1);
    send_a(8'hFF, 1'b1);
    ticks_a(16);

    rx_a = 1'b0;
    ticks_a(16);
    for (int i = 0; i < 3; i++) begin
      rx_a = i[0];
      ticks_a(16);
    end
    rx_a = 1'b0;
    ticks_a(8);
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout", {1'b0, dout_a}, 9'h000);
    check("t5_rst_flags", {6'd0, ferr_a, busy_a, done_a}, 9'h000);
    rx_a = 1'b1;
    ticks_a(4);
    rst_n = 1'b1;
    ticks_a(20);
    send_a(8'h81, 1'b1);
    ticks_a(8);
    check("t5_after", {ferr_a, dout_a}, 9'h081);

    for (int k = 0; k < 256; k++) begin
      d = 8'($urandom_range(0, 255));
      send_b(d);
    end
    ticks_b(40);

    check("a_queue_empty", 9'(sb_a.size()), 9'h000);
    check("a_strobes", 9'(strobes_a), 9'd6);
    check("b_queue_empty", 9'(sb_b.size()), 9'h000);
    check("b_strobes", 9'(strobes_b), 9'd256);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
